// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port wormhole router switch allocator.
//   NPORTS / SELW : default port count and port-index width
//   ost_e         : per-output allocation state (idle or locked to an owner)
//   P_*           : port index names for the mesh directions
package noc_pkg;

    localparam int NPORTS = 5;
    localparam int SELW   = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } ost_e;

    localparam int P_LOCAL = 0;
    localparam int P_N     = 1;
    localparam int P_E     = 2;
    localparam int P_S     = 3;
    localparam int P_W     = 4;

endpackage

// File: rtl/noc_rr_arbiter.sv
// N-wide round-robin arbiter, purely combinational.
//   req : request vector
//   ptr : highest-priority index; scan runs ptr, ptr+1, ... wrapping mod N
//   en  : when low, no grant is issued
//   gnt : one-hot grant
//   idx : encoded winner (0 when vld=0)
//   vld : a grant was issued
module noc_rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         vld
);

    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                c = (int'(ptr) + k) % N;
                if (!vld && req[c]) begin
                    vld    = 1'b1;
                    gnt[c] = 1'b1;
                    idx    = W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-output switch allocator for the wormhole router. Each output either
// arbitrates among head flits round-robin (IDLE) or follows the input that
// won its head flit until that packet's tail passes (LOCKED).
//   clk, rst        : clock, asynchronous active-low reset
//   in_valid/head/tail, in_dest : input buffer heads (dest slice i = [i*SELW +: SELW])
//   out_ready       : per-output downstream credit available
//   in_grant        : input i pops its flit this cycle
//   out_valid/out_sel : crossbar drive per output (sel is 0 when not valid)
//   err             : sticky, a valid head requested a non-existent output
module noc_switch_allocator
    import noc_pkg::*;
#(
    parameter int NPORTS = noc_pkg::NPORTS,
    parameter int SELW   = noc_pkg::SELW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORTS-1:0]      in_valid,
    input  logic [NPORTS-1:0]      in_head,
    input  logic [NPORTS-1:0]      in_tail,
    input  logic [NPORTS*SELW-1:0] in_dest,
    input  logic [NPORTS-1:0]      out_ready,
    output logic [NPORTS-1:0]      in_grant,
    output logic [NPORTS-1:0]      out_valid,
    output logic [NPORTS*SELW-1:0] out_sel,
    output logic                   err
);

    localparam logic [SELW:0]   NP_EXT = (SELW+1)'(NPORTS);
    localparam logic [SELW-1:0] LAST   = SELW'(NPORTS - 1);

    logic [NPORTS-1:0][SELW-1:0]   dest;
    logic [NPORTS-1:0][SELW-1:0]   sel;
    logic [NPORTS-1:0][NPORTS-1:0] ogrant;   // ogrant[o] = inputs granted by output o
    logic                          bad_head;

    assign dest    = in_dest;
    assign out_sel = sel;

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        ost_e              st;
        logic [SELW-1:0]   ptr;
        logic [SELW-1:0]   owner;
        logic [NPORTS-1:0] cand;
        logic [NPORTS-1:0] arb_gnt;
        logic [SELW-1:0]   arb_idx;
        logic              arb_vld;
        logic              arb_en;
        logic              lk_gnt;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NPORTS; i++)
                cand[i] = in_valid[i] & in_head[i] & (dest[i] == SELW'(o));
        end

        // rst gating keeps all grant outputs low for the whole reset window,
        // even though the inputs may still be presenting traffic.
        assign arb_en = rst & (st == ST_IDLE) & out_ready[o];
        assign lk_gnt = rst & (st == ST_LOCKED) & in_valid[owner] & out_ready[o];

        noc_rr_arbiter #(.N(NPORTS), .W(SELW)) u_arb (
            .req (cand),
            .ptr (ptr),
            .en  (arb_en),
            .gnt (arb_gnt),
            .idx (arb_idx),
            .vld (arb_vld)
        );

        assign ogrant[o]    = lk_gnt ? (NPORTS'(1) << owner) : arb_gnt;
        assign out_valid[o] = lk_gnt | arb_vld;
        assign sel[o]       = lk_gnt ? owner : arb_idx;

        // A tail grant returns to IDLE; a head waiting on the same output is
        // only considered by the arbiter on the following cycle.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st    <= ST_IDLE;
                ptr   <= '0;
                owner <= '0;
            end else if (arb_vld) begin
                ptr <= (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
                if (!in_tail[arb_idx]) begin
                    st    <= ST_LOCKED;
                    owner <= arb_idx;
                end
            end else if (lk_gnt && in_tail[owner]) begin
                st <= ST_IDLE;
            end
        end
    end

    // Upstream guarantees at most one output grants a given input.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NPORTS; o++)
            in_grant = in_grant | ogrant[o];
    end

    always_comb begin
        bad_head = 1'b0;
        for (int i = 0; i < NPORTS; i++)
            if (in_valid[i] && in_head[i] && ({1'b0, dest[i]} >= NP_EXT))
                bad_head = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (bad_head)
            err <= 1'b1;
    end

endmodule

// File: doc/noc_switch_allocator.md
Name: noc_switch_allocator

Overview:
- Per-output switch allocator for the 5-port wormhole router; shares each router output port among the five input ports.
- Uses the same one-hot req/gnt style as the existing 5-port arbiter, plus per-output round-robin priority and a packet lock held from head flit to tail flit.
- Sits between the input buffers (valid/dest/head/tail) and the crossbar select lines.
- Output credit status (out_ready) throttles each grant.

Parameters:
- NPORTS, 5: number of router ports (inputs = outputs). Supported range 2..8.
- SELW, 3: width of a port index; must satisfy 2**SELW >= NPORTS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  NPORTS  input i holds a flit at its buffer head.
- in_head  input  NPORTS  flit at input i is a head flit.
- in_tail  input  NPORTS  flit at input i is a tail flit. head&tail means a single-flit packet.
- in_dest  input  NPORTS*SELW  destination output index for input i; slice i = [i*SELW +: SELW].
- out_ready  input  NPORTS  output o can accept a flit this cycle (downstream credit > 0).
- in_grant  output  NPORTS  flit at input i is transferred this cycle; the input pops on this.
- out_valid  output  NPORTS  output o carries a flit this cycle.
- out_sel  output  NPORTS*SELW  crossbar select: input index driving output o. It is 0 when out_valid[o]=0.
- err  output  1  sticky: a valid head flit requested in_dest >= NPORTS.

Behaviour:
- Per-output state: IDLE or LOCKED(owner). Per-output round-robin pointer ptr[o] in 0..NPORTS-1.
- Reset (rst=0, asynchronous): all outputs go IDLE, ptr=0, err=0. Any lock in progress is dropped, with no completion of the partial packet. in_grant, out_valid and out_sel are 0 while in reset.
- Grants are combinational from the current inputs and registered state, i.e. zero-cycle latency. State updates on the next clk edge.
- IDLE, output o:
  - cand[i] = in_valid[i] & in_head[i] & (in_dest[i]==o).
  - If out_ready[o]=1 and cand is nonzero, the winner is the first set cand bit scanning ptr[o], ptr[o]+1, ..., wrapping mod NPORTS.
  - Assert in_grant[winner], out_valid[o]=1, out_sel[o]=winner.
  - Next ptr[o] = (winner+1) mod NPORTS.
  - Next state: IDLE if in_tail[winner], else LOCKED(winner).
- IDLE with out_ready[o]=0: no grant; ptr and state unchanged.
- LOCKED(w), output o:
  - Grant only if in_valid[w] & out_ready[o]. Flit head/dest fields are ignored; body flits follow the lock.
  - On a granted flit with in_tail[w]=1, go to IDLE. Otherwise stay LOCKED. ptr is unchanged while LOCKED.
  - Head flits from other inputs targeting o wait; they are not granted.
  - A bubble (in_valid[w]=0) or backpressure (out_ready[o]=0) holds the lock indefinitely.
- An input locked to output o never presents a head to another output mid-packet (guaranteed upstream). in_grant[i] is therefore the OR over outputs and at most one output grants any input.
- Invalid destination: a head with in_dest >= NPORTS matches no output, is never granted, and sets err on the next edge. err clears only on reset.
- A non-head flit at an input that owns no lock is never granted. This is not flagged as an error.
- Simultaneous events: a tail grant and a new head for the same output in the same cycle. The new head waits one cycle; re-arbitration happens in the IDLE state on the following cycle.
- Independent outputs may all grant in the same cycle (up to NPORTS transfers per cycle).

Decomposition:
- Shared package noc_pkg: NPORTS and SELW constants, per-output state encoding (ST_IDLE=1'b0, ST_LOCKED=1'b1), and port index constants (P_LOCAL=0, P_N=1, P_E=2, P_S=3, P_W=4).
- One sub-module, noc_rr_arbiter: NPORTS-wide round-robin arbiter (req vector, ptr, enable in; one-hot gnt and encoded index out). Instantiated once per output.
- noc_switch_allocator holds the lock FSMs, the pointers, the err flag and the grant OR-reduction.

Test Plan:
- Single-flit packet: in_valid[1]=1, head=tail=1, dest=3, out_ready=5'b11111.
  -> Same cycle: in_grant=5'b00010, out_valid[3]=1, out_sel[3]=1. Next cycle ptr[3]=2 and output 3 is IDLE.
- Round-robin fairness: inputs 0,1,2,4 all send single-flit heads to output 2 continuously, ptr[2]=0.
  -> Grants on consecutive cycles go to 0,1,2,4,0,...; input 3 is skipped.
- Wormhole lock: input 2 sends head(dest=4), body, body, tail on 4 cycles while input 0 holds a head to 4.
  -> out_sel[4]=2 for all 4 cycles. Input 0 is granted on cycle 5.
- Backpressure and bubble mid-packet: during a locked packet, out_ready[4]=0 for 2 cycles, then in_valid[2]=0 for 1 cycle.
  -> No grants during those 3 cycles. The lock is held and the packet resumes with out_sel[4]=2.
- Reset mid-packet: rst=0 asynchronously while output 4 is LOCKED(2).
  -> in_grant=0 and out_valid=0 immediately. After release, a head from input 0 to output 4 is granted at once (ptr=0).
- Bad destination: valid head with dest=6.
  -> No grant asserted; err=1 from the next edge and stays 1 until reset.
